instruction_fetch_queue: RTL

Parametrised successor to the single-register fetch stage. It keeps the fetch PC, issues one synchronous-read request per cycle to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake, so decode stalls no longer drop instructions. The branch predictor can redirect the PC; a redirect flushes the queue and discards any in-flight read.

---
 rtl/instruction_fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: keeps the fetch PC, issues one synchronous memory read per cycle and
// buffers the returned instructions with their PCs in a circular queue that feeds decode.
module instruction_fetch_queue #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned NOP         = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PC_WIDTH-1:0]          target_bp,
  input  logic                         target_en_bp,
  input  logic [INSTR_WIDTH-1:0]       data_from_memory,
  output logic [ADDR_WIDTH-1:0]        address_to_memory,
  output logic                         mem_req,
  output logic [PC_WIDTH-1:0]          pc_to_bp,
  output logic [PC_WIDTH-1:0]          next_program_counter_if_to_bp,
  output logic [INSTR_WIDTH-1:0]       instruction_if,
  output logic [PC_WIDTH-1:0]          pc_if,
  output logic [PC_WIDTH-1:0]          next_program_counter_if,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    tag_pc;
  logic                   inflight;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
  logic [PC_WIDTH-1:0]    q_pc    [DEPTH];

  logic                   pop;
  logic                   push;
  logic [CW:0]            occupancy;

  // Request only when the queue is guaranteed to have room for the return.
  always_comb begin
    pop       = (count != '0) && instr_ready;
    push      = inflight && !target_en_bp;
    occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    mem_req   = reset && !target_en_bp && (occupancy < (CW+1)'(DEPTH));
  end

  always_comb begin
    address_to_memory             = pc[ADDR_WIDTH-1:0];
    pc_to_bp                      = pc;
    next_program_counter_if_to_bp = pc + PC_WIDTH'(1);
    instr_valid                   = (count != '0);
    fifo_count                    = count;
    instruction_if                = INSTR_WIDTH'(NOP);
    pc_if                         = '0;
    next_program_counter_if       = '0;
    if (count != '0) begin
      instruction_if          = q_instr[rd_ptr];
      pc_if                   = q_pc[rd_ptr];
      next_program_counter_if = q_pc[rd_ptr] + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= PC_WIDTH'(RESET_PC);
      tag_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (target_en_bp) begin
      // Redirect flushes the queue and squashes any return arriving next cycle.
      pc       <= target_bp;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= mem_req;
      if (mem_req) begin
        tag_pc <= pc;
        pc     <= pc + PC_WIDTH'(1);
      end
      if (push) begin
        q_instr[wr_ptr] <= data_from_memory;
        q_pc[wr_ptr]    <= tag_pc;
        wr_ptr          <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
